// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
package bram_arb_pkg;

    localparam int unsigned ADDR_BITS_DEF = 14;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt,
    output logic       gnt_valid
);

    logic last;

    always_comb begin
        gnt = 1'b0;
        if (req == 2'b11)
            gnt = ~last;
        else
            gnt = req[1];
    end

    assign gnt_valid = |req;

    // Last-grant starts at 1 so the CPU port wins the first tie after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last <= 1'b1;
        else if (grant_en && gnt_valid)
            last <= gnt;
    end

endmodule

// File: rtl/bram_arbiter.sv
// Serialises the CPU and loader/DMA native memory ports onto RAM port A,
// covering the one-cycle synchronous read latency of the bank.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 m0_valid,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic                 m0_ready,
    output logic [31:0]          m0_rdata,

    input  logic                 m1_valid,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic                 m1_ready,
    output logic [31:0]          m1_rdata,

    output logic                 ram_ce,
    output logic [3:0]           ram_wre,
    output logic [ADDR_BITS-1:0] ram_ad,
    output logic [31:0]          ram_di,
    input  logic [31:0]          ram_do
);

    state_t      state;
    logic        gnt;
    logic        gnt_valid;
    logic        gidx;
    logic        is_read;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        unused_addr_bits;

    rr_arb2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       ({m1_valid, m0_valid}),
        .grant_en  (state == IDLE),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    assign sel_addr  = (gnt == REQ_DMA) ? m1_addr  : m0_addr;
    assign sel_wdata = (gnt == REQ_DMA) ? m1_wdata : m0_wdata;
    assign sel_wstrb = (gnt == REQ_DMA) ? m1_wstrb : m0_wstrb;

    // Byte-lane and upper address bits are deliberately ignored (aliasing).
    assign unused_addr_bits = ^{m0_addr[31:ADDR_BITS+2], m0_addr[1:0],
                                m1_addr[31:ADDR_BITS+2], m1_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            gidx     <= REQ_CPU;
            is_read  <= 1'b0;
            ram_ce   <= 1'b0;
            ram_wre  <= '0;
            ram_ad   <= '0;
            ram_di   <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gidx    <= gnt;
                        ram_ad  <= sel_addr[ADDR_BITS+1:2];
                        ram_di  <= sel_wdata;
                        ram_wre <= sel_wstrb;
                        is_read <= (sel_wstrb == 4'h0);
                        ram_ce  <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_ce   <= 1'b0;
                    ram_wre  <= '0;
                    m0_ready <= (gidx == REQ_CPU);
                    m1_ready <= (gidx == REQ_DMA);
                    state    <= RESP;
                end
                RESP: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_rdata = (m0_ready && is_read) ? ram_do : '0;
    assign m1_rdata = (m1_ready && is_read) ? ram_do : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter with a behavioural RAM bank.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce;
    logic [3:0]  ram_wre;
    logic [13:0] ram_ad;
    logic [31:0] ram_di;
    logic [31:0] ram_do = '0;

    logic [31:0] mem [0:16383];

    int tests = 0;
    int fails = 0;

    bram_arbiter #(.ADDR_BITS(14)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .ram_ce   (ram_ce),
        .ram_wre  (ram_wre),
        .ram_ad   (ram_ad),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 clk = ~clk;

    // Four byte lanes, read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_ce) begin
            for (int k = 0; k < 4; k++)
                if (ram_wre[k]) mem[ram_ad][8*k +: 8] <= ram_di[8*k +: 8];
            ram_do <= mem[ram_ad];
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic xfer(input bit p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        if (!p) begin
            m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
        lat = -1;
        rd = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (p ? m1_ready : m0_ready) begin
                rd = p ? m1_rdata : m0_rdata;
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
        if (!p) m0_valid = 1'b0; else m1_valid = 1'b0;
    endtask

    task automatic test_reset();
        m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
        m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (ram_ce !== 1'b0) begin fails++; $display("FAIL reset_ce: got %b expected 0", ram_ce); end
        tests++; if (ram_wre !== 4'h0) begin fails++; $display("FAIL reset_wre: got %h expected 0", ram_wre); end
        tests++; if (ram_ad !== 14'h0) begin fails++; $display("FAIL reset_ad: got %h expected 0", ram_ad); end
        tests++; if (ram_di !== 32'h0) begin fails++; $display("FAIL reset_di: got %h expected 0", ram_di); end
        tests++; if ({m0_ready, m1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", {m0_ready, m1_ready}); end
        tests++; if ({m0_rdata, m1_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if ({ram_ce, m0_ready, m1_ready} !== 3'b000) begin
                fails++; $display("FAIL idle_no_ce: got %b expected 000", {ram_ce, m0_ready, m1_ready});
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] rd;
        int lat;
        @(posedge clk); #1;
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
        @(negedge clk);
        tests++; if (ram_ce !== 1'b0) begin fails++; $display("FAIL wr_c0_ce: got %b expected 0", ram_ce); end
        @(negedge clk);
        tests++; if (ram_ce !== 1'b1) begin fails++; $display("FAIL wr_c1_ce: got %b expected 1", ram_ce); end
        tests++; if (ram_ad !== 14'h40) begin fails++; $display("FAIL wr_c1_ad: got %h expected 40", ram_ad); end
        tests++; if (ram_wre !== 4'hF) begin fails++; $display("FAIL wr_c1_wre: got %h expected f", ram_wre); end
        tests++; if (ram_di !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_c1_di: got %h expected deadbeef", ram_di); end
        @(negedge clk);
        tests++; if (m0_ready !== 1'b1) begin fails++; $display("FAIL wr_c2_ready: got %b expected 1", m0_ready); end
        tests++; if (ram_wre !== 4'h0) begin fails++; $display("FAIL wr_c2_wre: got %h expected 0", ram_wre); end
        tests++; if (m0_rdata !== 32'h0) begin fails++; $display("FAIL wr_rdata_zero: got %h expected 0", m0_rdata); end
        @(posedge clk); #1 m0_valid = 1'b0;
        xfer(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        int lat;
        xfer(1'b0, 32'h300, 32'h11223344, 4'hF, rd, lat);
        xfer(1'b0, 32'h300, 32'h000000AA, 4'h1, rd, lat);
        xfer(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'h112233AA) begin fails++; $display("FAIL strobe_lane0: got %h expected 112233aa", rd); end
        xfer(1'b1, 32'h300, 32'h55667788, 4'h6, rd, lat);
        xfer(1'b1, 32'h302, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'h116677AA) begin fails++; $display("FAIL strobe_mid_lanes: got %h expected 116677aa", rd); end
        xfer(1'b0, 32'h0001_0300, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'h116677AA) begin fails++; $display("FAIL addr_alias: got %h expected 116677aa", rd); end
    endtask

    task automatic test_tie();
        int t0, t1;
        logic [31:0] rd0, rd1;
        bit both;
        t0 = -1; t1 = -1; rd0 = '0; rd1 = '0; both = 1'b0;
        do_reset();
        @(posedge clk); #1;
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m0_ready && m1_ready) both = 1'b1;
            if (m0_ready) begin t0 = c; rd0 = m0_rdata; end
            if (m1_ready) begin t1 = c; rd1 = m1_rdata; end
            @(posedge clk); #1;
            if (t0 >= 0) m0_valid = 1'b0;
            if (t1 >= 0) m1_valid = 1'b0;
        end
        tests++; if (t0 !== 2) begin fails++; $display("FAIL tie_m0_cycle: got %0d expected 2", t0); end
        tests++; if (t1 !== 5) begin fails++; $display("FAIL tie_m1_cycle: got %0d expected 5", t1); end
        tests++; if (rd0 !== 32'hDEADBEEF) begin fails++; $display("FAIL tie_m0_data: got %h expected deadbeef", rd0); end
        tests++; if (rd1 !== 32'h116677AA) begin fails++; $display("FAIL tie_m1_data: got %h expected 116677aa", rd1); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL tie_overlap: got %b expected 0", both); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit both;
        n = 0; both = 1'b0;
        @(posedge clk); #1;
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (m0_ready && m1_ready) both = 1'b1;
            if (m0_ready || m1_ready) begin
                tests++;
                if (m1_ready !== n[0]) begin
                    fails++; $display("FAIL b2b_port[%0d]: got %b expected %b", n, m1_ready, n[0]);
                end
                tests++;
                if (c !== 2 + 3 * n) begin
                    fails++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", n, c, 2 + 3 * n);
                end
                n++;
                if (n == 12) break;
            end
        end
        @(posedge clk); #1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        tests++; if (n !== 12) begin fails++; $display("FAIL b2b_count: got %0d expected 12", n); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL b2b_overlap: got %b expected 0", both); end
    endtask

    task automatic test_valid_drop();
        logic [31:0] rd;
        int lat;
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = 32'h500; m1_wdata = 32'h0BADF00D; m1_wstrb = 4'hF;
        @(posedge clk); #1;
        m1_valid = 1'b0; m1_addr = 32'h600; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        @(negedge clk);
        tests++; if (ram_ad !== 14'h140) begin fails++; $display("FAIL drop_ad: got %h expected 140", ram_ad); end
        tests++; if (ram_di !== 32'h0BADF00D) begin fails++; $display("FAIL drop_di: got %h expected 0badf00d", ram_di); end
        @(negedge clk);
        tests++; if (m1_ready !== 1'b1) begin fails++; $display("FAIL drop_ready: got %b expected 1", m1_ready); end
        xfer(1'b0, 32'h500, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL drop_readback: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        xfer(1'b0, 32'h200, 32'hCAFEF00D, 4'hF, rd, lat);
        @(posedge clk); #1;
        m0_valid = 1'b1; m0_addr = 32'h200; m0_wdata = 32'h12345678; m0_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        tests++; if (ram_ce !== 1'b1) begin fails++; $display("FAIL mid_access_ce: got %b expected 1", ram_ce); end
        resetn = 1'b0;
        #1;
        tests++; if ({ram_ce, ram_wre} !== 5'b0) begin fails++; $display("FAIL mid_reset_ce_wre: got %b expected 0", {ram_ce, ram_wre}); end
        tests++; if (ram_ad !== 14'h0) begin fails++; $display("FAIL mid_reset_ad: got %h expected 0", ram_ad); end
        m0_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({m0_ready, m1_ready} !== 2'b00) begin
                fails++; $display("FAIL mid_no_ready: got %b expected 00", {m0_ready, m1_ready});
            end
        end
        @(posedge clk); #1 resetn = 1'b1;
        xfer(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL mid_prewrite_kept: got %h expected cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_tie();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
